sap1_sequencer: RTL and testbench
=================================

SAP1_SEQUENCER -- requirements
Module: sap1_sequencer

Interface
REQ-001 The block SHALL have one parameter: EARLY_END, default 0, meaning 1 = return to T1 immediately after the last active T-state of each instruction.
REQ-002 The block SHALL have port sysclk, input, 1 bit: system clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port clken, input, 1 bit: clock enable; the state advances only on edges where clken=1.
REQ-005 The block SHALL have port opcode, input, 4 bits: instruction register upper nibble.
REQ-006 The block SHALL have these 1-bit outputs: pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out, a_load, a_out, b_load, alu_out, alu_sub, out_load.
REQ-007 The block SHALL have port tstate, output, 6 bits: one-hot current T-state, bit0 = T1 .. bit5 = T6; all zeros in HALT.
REQ-008 The block SHALL have port halted, output, 1 bit: 1 while in HALT.

Function
REQ-009 The block SHALL have states T1..T6 and HALT, held in registers; control outputs SHALL be a combinational decode of the state and opcode, stable for the whole T-state.
REQ-010 On an edge with clken=0 the state SHALL hold, and outputs SHALL not change unless opcode changes.
REQ-011 Fetch SHALL be identical for all opcodes:
- T1: pc_out, mar_load
- T2: pc_inc
- T3: ram_out, ir_load
REQ-012 LDA (0000) SHALL be:
- T4: ir_out, mar_load
- T5: ram_out, a_load
- T6: none
REQ-013 ADD (0001) SHALL be:
- T4: ir_out, mar_load
- T5: ram_out, b_load
- T6: alu_out, a_load
REQ-014 SUB (0010) SHALL match ADD, with alu_sub also asserted in T5 and T6.
REQ-015 OUT (1110) SHALL be:
- T4: a_out, out_load
- T5, T6: none
REQ-016 HLT (1111) SHALL assert no controls in T4; the next enabled edge SHALL go to HALT.
REQ-017 HALT SHALL be absorbing (only reset exits), with all controls 0, halted=1, tstate=0.
REQ-018 All other opcodes SHALL be NOP: no controls in T4..T6.
REQ-019 With EARLY_END=0, the enabled-edge sequence SHALL be T1→T2→…→T6→T1 for every non-HLT opcode.
REQ-020 With EARLY_END=1, the last state before T1 SHALL be:
- LDA: T5
- OUT: T4
- NOP: T3 (opcode sampled at T3 as the IR is loading; the T3→T1 decision uses the opcode input value present at that edge)
- ADD/SUB: T6
- HLT: T4→HALT, unchanged
REQ-021 In every state, at most one of pc_out, ram_out, ir_out, a_out, alu_out SHALL be 1 (bus exclusivity).
REQ-022 Outputs not listed for a state SHALL be 0.

Reset
REQ-023 On an edge with reset=1 the block SHALL go to T1 and clear halted, regardless of clken or current state (including HALT and mid-instruction).
REQ-024 While reset=1, all control outputs SHALL be forced to 0 and tstate SHALL read 000001.
REQ-025 The first T1 controls (pc_out, mar_load) SHALL appear in the first cycle after reset deasserts.

Verification
REQ-026 Reset then clken=1 with opcode=0001, EARLY_END=0 -> tstate 000001,000010,…,100000,000001 on successive edges; a_load=1 only in T6; b_load=1 only in T5.
REQ-027 clken pattern 1,0,0,1 from T1 -> tstate T2 held for 3 edges, then T3; outputs constant while held.
REQ-028 opcode=1111 -> after T4 edge, halted=1, tstate=000000, all controls 0 for 20 edges; reset=1 for one edge -> T1, halted=0.
REQ-029 EARLY_END=1, opcodes 1110 then 0000 then 0101 -> cycle lengths 4, 5 and 3 T-states respectively.
REQ-030 reset asserted in T5 of SUB with clken=0 -> next edge tstate=000001, alu_sub=0; bus-exclusivity assertion checked every cycle of a random-opcode run.

Source files
------------

// File: rtl/sap1_sequencer.sv
// SAP-1 control sequencer: T1..T6 ring plus an absorbing HALT state.
// The control word is a combinational decode of the T-state and the opcode.
//
// state | meaning
// T1    | fetch: PC onto bus, load MAR
// T2    | fetch: increment PC
// T3    | fetch: RAM onto bus, load IR (the NOP early exit is decided here)
// T4    | execute step 1 (LDA/ADD/SUB address, OUT transfer, HLT decision)
// T5    | execute step 2 (RAM operand into A or B)
// T6    | execute step 3 (ALU result into A)
// HALT  | stopped; only reset leaves this state
module sap1_sequencer #(
  parameter bit EARLY_END = 1'b0
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       clken,
  input  logic [3:0] opcode,
  output logic       pc_inc,
  output logic       pc_out,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ir_load,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       b_load,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       out_load,
  output logic [5:0] tstate,
  output logic       halted
);

  typedef enum logic [2:0] {
    T1   = 3'd0,
    T2   = 3'd1,
    T3   = 3'd2,
    T4   = 3'd3,
    T5   = 3'd4,
    T6   = 3'd5,
    HALT = 3'd6
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t state;
  state_t state_d;

  logic is_lda;
  logic is_add;
  logic is_sub;
  logic is_out;
  logic is_hlt;
  logic is_nop;
  logic is_mem;

  assign is_lda = (opcode == OP_LDA);
  assign is_add = (opcode == OP_ADD);
  assign is_sub = (opcode == OP_SUB);
  assign is_out = (opcode == OP_OUT);
  assign is_hlt = (opcode == OP_HLT);
  assign is_nop = ~(is_lda | is_add | is_sub | is_out | is_hlt);
  assign is_mem = is_lda | is_add | is_sub;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= T1;
    end else if (clken) begin
      state <= state_d;
    end
  end

  // Early exits use the opcode present at the deciding edge.
  always_comb begin
    state_d = state;
    case (state)
      T1:      state_d = T2;
      T2:      state_d = T3;
      T3:      state_d = (EARLY_END && is_nop) ? T1 : T4;
      T4: begin
        if (is_hlt) begin
          state_d = HALT;
        end else if (EARLY_END && is_out) begin
          state_d = T1;
        end else begin
          state_d = T5;
        end
      end
      T5:      state_d = (EARLY_END && is_lda) ? T1 : T6;
      T6:      state_d = T1;
      HALT:    state_d = HALT;
      default: state_d = T1;
    endcase
  end

  // Reset masks every control and makes the T-state read as T1.
  always_comb begin
    pc_inc   = 1'b0;
    pc_out   = 1'b0;
    mar_load = 1'b0;
    ram_out  = 1'b0;
    ir_load  = 1'b0;
    ir_out   = 1'b0;
    a_load   = 1'b0;
    a_out    = 1'b0;
    b_load   = 1'b0;
    alu_out  = 1'b0;
    alu_sub  = 1'b0;
    out_load = 1'b0;
    tstate   = 6'b000000;
    halted   = 1'b0;
    if (reset) begin
      tstate = 6'b000001;
    end else begin
      case (state)
        T1: begin
          tstate   = 6'b000001;
          pc_out   = 1'b1;
          mar_load = 1'b1;
        end
        T2: begin
          tstate = 6'b000010;
          pc_inc = 1'b1;
        end
        T3: begin
          tstate  = 6'b000100;
          ram_out = 1'b1;
          ir_load = 1'b1;
        end
        T4: begin
          tstate = 6'b001000;
          if (is_mem) begin
            ir_out   = 1'b1;
            mar_load = 1'b1;
          end else if (is_out) begin
            a_out    = 1'b1;
            out_load = 1'b1;
          end
        end
        T5: begin
          tstate = 6'b010000;
          if (is_lda) begin
            ram_out = 1'b1;
            a_load  = 1'b1;
          end else if (is_add || is_sub) begin
            ram_out = 1'b1;
            b_load  = 1'b1;
            alu_sub = is_sub;
          end
        end
        T6: begin
          tstate = 6'b100000;
          if (is_add || is_sub) begin
            alu_out = 1'b1;
            a_load  = 1'b1;
            alu_sub = is_sub;
          end
        end
        HALT: begin
          halted = 1'b1;
        end
        default: begin
          tstate = 6'b000000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sap1_sequencer.sv
// Bench for sap1_sequencer: both EARLY_END variants share stimulus and are
// compared every cycle against a microcode-table model, plus literal checks.
module tb_sap1_sequencer;

  localparam logic [11:0] PC_INC   = 12'h800;
  localparam logic [11:0] PC_OUT   = 12'h400;
  localparam logic [11:0] MAR_LOAD = 12'h200;
  localparam logic [11:0] RAM_OUT  = 12'h100;
  localparam logic [11:0] IR_LOAD  = 12'h080;
  localparam logic [11:0] IR_OUT   = 12'h040;
  localparam logic [11:0] A_LOAD   = 12'h020;
  localparam logic [11:0] A_OUT    = 12'h010;
  localparam logic [11:0] B_LOAD   = 12'h008;
  localparam logic [11:0] ALU_OUT  = 12'h004;
  localparam logic [11:0] ALU_SUB  = 12'h002;
  localparam logic [11:0] OUT_LOAD = 12'h001;
  localparam logic [11:0] BUS_MASK = PC_OUT | RAM_OUT | IR_OUT | A_OUT | ALU_OUT;

  localparam logic [11:0] FETCH_UC [3] = '{PC_OUT | MAR_LOAD, PC_INC, RAM_OUT | IR_LOAD};
  // rows: LDA, ADD, SUB, OUT, NOP/HLT; columns: T4, T5, T6
  localparam logic [11:0] EXEC_UC [5][3] = '{
    '{IR_OUT | MAR_LOAD, RAM_OUT | A_LOAD, 12'h000},
    '{IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD, ALU_OUT | A_LOAD},
    '{IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD | ALU_SUB, ALU_OUT | A_LOAD | ALU_SUB},
    '{A_OUT | OUT_LOAD, 12'h000, 12'h000},
    '{12'h000, 12'h000, 12'h000}
  };

  logic        sysclk = 1'b0;
  logic        reset;
  logic        clken;
  logic [3:0]  opcode;
  logic [11:0] c0, c1;
  logic [5:0]  ts0, ts1;
  logic        h0, h1;

  int checks = 0;
  int errors = 0;
  int m0, m1;          // model T-state number, 0 = HALT
  bit mvalid = 1'b0;

  always #5 sysclk = ~sysclk;

  sap1_sequencer #(.EARLY_END(1'b0)) u_dut0 (
    .sysclk(sysclk), .reset(reset), .clken(clken), .opcode(opcode),
    .pc_inc(c0[11]), .pc_out(c0[10]), .mar_load(c0[9]), .ram_out(c0[8]),
    .ir_load(c0[7]), .ir_out(c0[6]), .a_load(c0[5]), .a_out(c0[4]),
    .b_load(c0[3]), .alu_out(c0[2]), .alu_sub(c0[1]), .out_load(c0[0]),
    .tstate(ts0), .halted(h0)
  );

  sap1_sequencer #(.EARLY_END(1'b1)) u_dut1 (
    .sysclk(sysclk), .reset(reset), .clken(clken), .opcode(opcode),
    .pc_inc(c1[11]), .pc_out(c1[10]), .mar_load(c1[9]), .ram_out(c1[8]),
    .ir_load(c1[7]), .ir_out(c1[6]), .a_load(c1[5]), .a_out(c1[4]),
    .b_load(c1[3]), .alu_out(c1[2]), .alu_sub(c1[1]), .out_load(c1[0]),
    .tstate(ts1), .halted(h1)
  );

  function automatic int op_class(input logic [3:0] op);
    case (op)
      4'b0000: return 0;
      4'b0001: return 1;
      4'b0010: return 2;
      4'b1110: return 3;
      default: return 4;
    endcase
  endfunction

  // Final T-state of an instruction when early return is enabled.
  function automatic int last_t(input logic [3:0] op, input bit early);
    if (!early) return 6;
    case (op)
      4'b0000: return 5;
      4'b1110: return 4;
      4'b0001, 4'b0010, 4'b1111: return 6;
      default: return 3;
    endcase
  endfunction

  function automatic int next_t(input int t, input logic [3:0] op, input bit early);
    if (t == 0) return 0;
    if (t == 4 && op == 4'b1111) return 0;
    if (t == 6 || t == last_t(op, early)) return 1;
    return t + 1;
  endfunction

  function automatic logic [11:0] ucode(input int t, input logic [3:0] op);
    if (t == 0) return 12'h000;
    if (t <= 3) return FETCH_UC[t-1];
    return EXEC_UC[op_class(op)][t-4];
  endfunction

  always @(posedge sysclk) begin
    if (reset) begin
      m0 <= 1;
      m1 <= 1;
      mvalid <= 1'b1;
    end else if (clken) begin
      m0 <= next_t(m0, opcode, 1'b0);
      m1 <= next_t(m1, opcode, 1'b1);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string nm, input int t, input logic [11:0] c,
                         input logic [5:0] ts, input logic h);
    logic [5:0]  exp_ts;
    logic [11:0] exp_c;
    exp_ts = reset ? 6'b000001 : ((t == 0) ? 6'b000000 : 6'(1 << (t - 1)));
    exp_c  = reset ? 12'h000 : ucode(t, opcode);
    chk({nm, "_tstate"}, int'(ts), int'(exp_ts));
    chk({nm, "_ctrl"}, int'(c), int'(exp_c));
    chk({nm, "_halted"}, int'(h), int'(!reset && t == 0));
    checks++;
    if ($countones(c & BUS_MASK) > 1) begin
      errors++;
      $display("FAIL %s_bus_excl: drivers %03h expected at most one", nm, c & BUS_MASK);
    end
  endtask

  always @(negedge sysclk) begin
    if (mvalid) begin
      cmp_dut("ee0", m0, c0, ts0, h0);
      cmp_dut("ee1", m1, c1, ts1, h1);
    end
  end

  task automatic drive(input logic r, input logic ce, input logic [3:0] op);
    reset = r;
    clken = ce;
    opcode = op;
    #1;
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] op);
    drive(1'b1, 1'b0, op);
    tick();
  endtask

  task automatic measure(input logic [3:0] op, input int exp_len, input string nm);
    int n;
    n = 0;
    drive(1'b0, 1'b1, op);
    do begin
      tick();
      n++;
    end while (ts1 != 6'b000001 && n < 12);
    chk(nm, n, exp_len);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops [6] = '{4'h0, 4'h1, 4'h2, 4'hE, 4'hF, 4'h5};
    logic [3:0] op;
    drive(1'b1, 1'b0, 4'h1);
    tick();
    chk("rst_tstate", ts0, 6'b000001);
    chk("rst_ctrl", c0, 12'h000);
    chk("rst_halted", h0, 0);

    // first T1 controls right after reset release, then the ADD walk
    drive(1'b0, 1'b1, 4'h1);
    chk("first_t1_ctrl", c0, PC_OUT | MAR_LOAD);
    for (int i = 0; i < 6; i++) begin
      chk("add_tstate", ts0, 1 << i);
      chk("add_a_load", c0[5], (i == 5) ? 1 : 0);
      chk("add_b_load", c0[3], (i == 4) ? 1 : 0);
      tick();
    end
    chk("add_wrap", ts0, 6'b000001);

    // clken 1,0,0,1
    do_reset(4'h0);
    drive(1'b0, 1'b1, 4'h0);
    tick();
    chk("hold_t2_a", ts0, 6'b000010);
    drive(1'b0, 1'b0, 4'h0);
    tick();
    chk("hold_t2_b", ts0, 6'b000010);
    chk("hold_ctrl_b", c0, PC_INC);
    tick();
    chk("hold_t2_c", ts0, 6'b000010);
    chk("hold_ctrl_c", c0, PC_INC);
    drive(1'b0, 1'b1, 4'h0);
    tick();
    chk("hold_to_t3", ts0, 6'b000100);

    // HLT is absorbing until reset
    do_reset(4'hF);
    drive(1'b0, 1'b1, 4'hF);
    tick(); tick(); tick();
    chk("hlt_t4", ts0, 6'b001000);
    chk("hlt_t4_ctrl", c0, 12'h000);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("halt_flag", h0, 1);
      chk("halt_tstate", ts0, 0);
      chk("halt_ctrl", c0, 12'h000);
      chk("halt_flag_ee1", h1, 1);
      drive(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      tick();
    end
    do_reset(4'h0);
    chk("halt_exit_ts", ts0, 6'b000001);
    chk("halt_exit_flag", h0, 0);

    // early-end cycle lengths
    do_reset(4'hE);
    measure(4'hE, 4, "ee_len_out");
    measure(4'h0, 5, "ee_len_lda");
    measure(4'h5, 3, "ee_len_nop");

    // reset in T5 of SUB with clken low
    do_reset(4'h2);
    drive(1'b0, 1'b1, 4'h2);
    tick(); tick(); tick(); tick();
    chk("sub_t5", ts0, 6'b010000);
    chk("sub_t5_alu_sub", c0[1], 1);
    drive(1'b1, 1'b0, 4'h2);
    chk("sub_rst_alu_sub", c0[1], 0);
    tick();
    chk("sub_rst_ts", ts0, 6'b000001);
    chk("sub_rst_alu_sub2", c0[1], 0);

    // random run
    op = 4'h1;
    drive(1'b0, 1'b1, op);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0)
        op = ($urandom_range(0, 1) == 1) ? ops[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0), op);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
